uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Serial-to-parallel 8N1 UART receiver. Samples the board serial_in pin and
//   presents received bytes on a ready/valid byte interface. Sits directly
//   upstream of the IO controller, which pops bytes via data_out_ready on
//   CPU reads of the UART RX data register and reads data_out_valid as status.
// PARAMETERS
//   CLOCK_FREQ  125_000_000  core clock frequency, Hz
//   BAUD_RATE   115_200      line rate, bit/s
//   (derived) SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE; SAMPLE_TIME = SYMBOL_EDGE_TIME/2;
//             CLK_CNT_W = $clog2(SYMBOL_EDGE_TIME)
// PORTS
//   clk             in   1  core clock, all logic on posedge
//   rst             in   1  asynchronous, active-low reset
//   serial_in       in   1  async UART line, idle high
//   data_out        out  8  received byte, LSB = first data bit
//   data_out_valid  out  1  byte available
//   data_out_ready  in   1  consumer accepts byte this cycle
//   overrun         out  1  sticky: unread byte was overwritten (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=0, async): FSM=IDLE, counters 0, data_out=8'h00,
//   data_out_valid=0, overrun=0, sync flops=1 (line idle).
// - serial_in passes a 2-flop synchronizer; rx_s = sync output, rx_q = rx_s delayed 1.
// - FSM states IDLE, START, DATA, STOP; clk_cnt counts 0..SYMBOL_EDGE_TIME-1.
//   IDLE : start on falling edge only (rx_q=1 & rx_s=0) -> START, clk_cnt=0.
//          A held-low line (break) never retriggers.
//   START: at clk_cnt==SAMPLE_TIME-1 sample rx_s; 1 -> IDLE (glitch reject);
//          0 -> DATA, clk_cnt=0, bit_cnt=0.
//   DATA : at clk_cnt==SYMBOL_EDGE_TIME-1 shift rx_s into MSB of shift reg
//          (LSB-first line order), clk_cnt=0, bit_cnt++; after 8th bit -> STOP.
//   STOP : at clk_cnt==SYMBOL_EDGE_TIME-1 sample rx_s; 1 -> commit byte, IDLE;
//          0 (framing error) -> discard byte, IDLE, no flag.
// - Sampling lands at bit centres; state transitions at sample points only.
// - Commit: next posedge data_out<=shift reg, data_out_valid<=1.
//   Latency: serial_in stop-bit centre to data_out_valid = 2 sync + 1 reg cycles.
// - Handshake: fire = data_out_valid & data_out_ready. On fire valid clears next
//   cycle. data_out stable while valid=1 and no commit occurs. ready ignored when valid=0.
// - Commit while valid=1 and no fire: data_out overwritten with new byte,
//   valid stays 1, overrun event.
// - Commit in same cycle as fire: new byte loaded, valid stays 1, no overrun.
// - rst asserted mid-frame: frame abandoned, all state to reset values.
// CONFIGURATION
//   UART_RX_OVERRUN_EN defined: overrun sets on overrun event, stays 1 until
//   the next fire (cleared same edge), set wins if both in one cycle.
//   Not defined: overrun tied 0, no flop; overwrite behaviour unchanged.
// STRUCTURE
//   uart_pkg: rx_state_t enum {IDLE,START,DATA,STOP}, UART_DATA_W=8 localparam.
//   Sub-module sync_2ff (2-flop synchronizer, async active-low reset, reset value
//   parameter) instantiated for serial_in; reused later by the transmitter path.
// TESTING (bench: CLOCK_FREQ=1000, BAUD_RATE=100 -> 10 clk/bit, ready held 1 unless stated)
//   1 Send 0xA5 (8N1) -> data_out=0xA5, valid pulses 1 cycle, ~3 cycles after stop-bit centre.
//   2 Send 0x3C then 0x81 with ready=0, then ready=1 -> data_out=0x81, valid 1 cycle;
//     overrun=1 until fire (macro on), 0 throughout (macro off).
//   3 3-cycle low glitch on idle line -> no valid, FSM back to IDLE; next 0x55 received ok.
//   4 Send 0xFF with stop bit driven 0, then line high -> no valid; following 0x12 received.
//   5 Assert rst at data bit 4 of 0x5A, release, send 0x69 -> only 0x69 delivered,
//     all outputs 0 during reset.
//   6 Back-to-back 0x00,0xFF,0x01 no idle gap, ready=1 -> three valids in order, overrun=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: receiver FSM state encoding and data width.
package uart_pkg;
    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single async level; 2-cycle latency, no backpressure.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver to ready/valid byte port; valid 3 cycles after stop-bit centre, a commit
// while valid overwrites data_out. UART_RX_OVERRUN_EN adds the sticky overrun flag.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   serial_in,
    output logic [UART_DATA_W-1:0] data_out,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic                   overrun
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CLK_CNT_W        = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CLK_CNT_W-1:0] SAMPLE_LAST = CLK_CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CLK_CNT_W-1:0] SYMBOL_LAST = CLK_CNT_W'(SYMBOL_EDGE_TIME - 1);

    rx_state_t              state_q;
    logic [CLK_CNT_W-1:0]   clk_cnt_q;
    logic [2:0]             bit_cnt_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic [UART_DATA_W-1:0] data_q;
    logic                   valid_q;
    logic                   rx_q;
    logic                   rx_s;
    logic                   fire;
    logic                   commit;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (serial_in),
        .q_o   (rx_s)
    );

    assign fire   = valid_q & data_out_ready;
    assign commit = (state_q == STOP) && (clk_cnt_q == SYMBOL_LAST) && rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            rx_q      <= 1'b1;
        end else begin
            rx_q <= rx_s;
            case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    // Edge-triggered so a held-low break line cannot restart a frame.
                    if (rx_q && !rx_s) state_q <= START;
                end
                START: begin
                    if (clk_cnt_q == SAMPLE_LAST) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt_q == SYMBOL_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_s, shift_q[UART_DATA_W-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt_q == SYMBOL_LAST) begin
                        clk_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (commit) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (fire) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;

`ifdef UART_RX_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else if (commit && valid_q && !data_out_ready) begin
            overrun_q <= 1'b1;
        end else if (fire) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 10 clocks per bit.
module tb_uart_receiver;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b1;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    int valid_cnt = 0;
    int ovr_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] rxq[$];
    logic exp_ovr;

    uart_receiver #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (data_out_valid && !prev_valid) rise_cyc = cyc;
            if (data_out_valid) valid_cnt++;
            if (data_out_valid && data_out_ready) rxq.push_back(data_out);
            if (overrun) ovr_cnt++;
        end
        prev_valid = data_out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_b);
        logic [9:0] fr;
        fr = {stop_b, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            serial_in = fr[i];
            repeat (10) tick();
        end
        serial_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({data_out, data_out_valid, overrun} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h/%b/%b want 00/0/0", data_out, data_out_valid, overrun);
        end
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        end
        rst = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_single_byte();
        int v0;
        int o0;
        rxq.delete();
        v0 = valid_cnt;
        o0 = ovr_cnt;
        send_byte(8'hA5, 1'b1);
        repeat (5) tick();
        n_cmp++;
        if (rxq.size() != 1) begin
            n_err++;
            $display("FAIL a5_count: got %0d want 1", rxq.size());
        end else begin
            n_cmp++;
            if (rxq[0] !== 8'hA5) begin
                n_err++;
                $display("FAIL a5_data: got %h want a5", rxq[0]);
            end
        end
        n_cmp++;
        if (rise_cyc - start_cyc != 99) begin
            n_err++;
            $display("FAIL a5_latency: got %0d want 99", rise_cyc - start_cyc);
        end
        n_cmp++;
        if (valid_cnt - v0 != 1) begin
            n_err++;
            $display("FAIL a5_valid_width: got %0d want 1", valid_cnt - v0);
        end
        n_cmp++;
        if (ovr_cnt != o0) begin
            n_err++;
            $display("FAIL a5_overrun: got %0d cycles want 0", ovr_cnt - o0);
        end
    endtask

    task automatic test_overrun();
`ifdef UART_RX_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        rxq.delete();
        data_out_ready = 1'b0;
        send_byte(8'h3C, 1'b1);
        repeat (3) tick();
        n_cmp++;
        if ({data_out, data_out_valid, overrun} !== {8'h3C, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL ovr_first: got %h/%b/%b want 3c/1/0", data_out, data_out_valid, overrun);
        end
        send_byte(8'h81, 1'b1);
        repeat (3) tick();
        n_cmp++;
        if ({data_out, data_out_valid, overrun} !== {8'h81, 1'b1, exp_ovr}) begin
            n_err++;
            $display("FAIL ovr_second: got %h/%b/%b want 81/1/%b", data_out, data_out_valid, overrun, exp_ovr);
        end
        n_cmp++;
        if (rxq.size() != 0) begin
            n_err++;
            $display("FAIL ovr_no_fire: got %0d pops want 0", rxq.size());
        end
        data_out_ready = 1'b1;
        tick();
        n_cmp++;
        if ({data_out_valid, overrun} !== 2'b00) begin
            n_err++;
            $display("FAIL ovr_after_fire: got %b/%b want 0/0", data_out_valid, overrun);
        end
        n_cmp++;
        if (rxq.size() != 1 || rxq[0] !== 8'h81) begin
            n_err++;
            $display("FAIL ovr_popped: got n=%0d first=%h want n=1 81", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        repeat (5) tick();
    endtask

    task automatic test_glitch();
        rxq.delete();
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (12) tick();
        n_cmp++;
        if (dut.state_q !== IDLE || data_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_reject: got state %0d valid %b want IDLE 0", dut.state_q, data_out_valid);
        end
        send_byte(8'h55, 1'b1);
        repeat (5) tick();
        n_cmp++;
        if (rxq.size() != 1 || rxq[0] !== 8'h55) begin
            n_err++;
            $display("FAIL glitch_next: got n=%0d first=%h want n=1 55", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
    endtask

    task automatic test_framing();
        rxq.delete();
        send_byte(8'hFF, 1'b0);
        repeat (20) tick();
        n_cmp++;
        if (rxq.size() != 0) begin
            n_err++;
            $display("FAIL frame_discard: got %0d pops want 0", rxq.size());
        end
        send_byte(8'h12, 1'b1);
        repeat (5) tick();
        n_cmp++;
        if (rxq.size() != 1 || rxq[0] !== 8'h12) begin
            n_err++;
            $display("FAIL frame_next: got n=%0d first=%h want n=1 12", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
    endtask

    task automatic test_mid_reset();
        logic [9:0] fr;
        fr = {1'b1, 8'h5A, 1'b0};
        rxq.delete();
        for (int i = 0; i < 5; i++) begin
            serial_in = fr[i];
            repeat (10) tick();
        end
        serial_in = fr[5];
        repeat (5) tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({data_out, data_out_valid, overrun} !== 10'b0) begin
                n_err++;
                $display("FAIL midrst_outputs[%0d]: got %h/%b/%b want 00/0/0", i, data_out, data_out_valid, overrun);
            end
        end
        serial_in = 1'b1;
        rst = 1'b1;
        repeat (20) tick();
        send_byte(8'h69, 1'b1);
        repeat (5) tick();
        n_cmp++;
        if (rxq.size() != 1 || rxq[0] !== 8'h69) begin
            n_err++;
            $display("FAIL midrst_only_69: got n=%0d first=%h want n=1 69", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        int o0;
        exp[0] = 8'h00;
        exp[1] = 8'hFF;
        exp[2] = 8'h01;
        rxq.delete();
        o0 = ovr_cnt;
        for (int i = 0; i < 3; i++) send_byte(exp[i], 1'b1);
        repeat (5) tick();
        n_cmp++;
        if (rxq.size() != 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d want 3", rxq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (rxq[i] !== exp[i]) begin
                    n_err++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", i, rxq[i], exp[i]);
                end
            end
        end
        n_cmp++;
        if (ovr_cnt != o0) begin
            n_err++;
            $display("FAIL b2b_overrun: got %0d cycles want 0", ovr_cnt - o0);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overrun();
        test_glitch();
        test_framing();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
